// File: rtl/commit_trace_buffer_pkg.sv
// Shared definitions for the commit trace buffer: record kinds, record
// layout and a helper that assembles a record from its fields.
package trace_pkg;

  localparam logic TRACE_GRF = 1'b0;
  localparam logic TRACE_DM  = 1'b1;

  // Record = kind + pc + addr + data.
  localparam int TRACE_W  = 97;
  localparam int OFF_DATA = 0;
  localparam int OFF_ADDR = 32;
  localparam int OFF_PC   = 64;
  localparam int OFF_KIND = 96;

  // Field order matches the offsets above (kind in the MSB, data in the LSBs).
  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  function automatic trace_rec_t mk_rec(input logic        kind,
                                        input logic [31:0] pc,
                                        input logic [31:0] addr,
                                        input logic [31:0] data);
    trace_rec_t r;
    r.kind = kind;
    r.pc   = pc;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side tap plus consumer read port of the trace buffer.
// Handshake: a record transfers on a rising clk edge where rd_valid && rd_ready;
// rd_valid never waits on rd_ready, and while rd_valid && !rd_ready the head
// fields hold stable. The commit inputs have no handshake: the core never stalls.
interface commit_trace_buffer_if #(
  parameter int AW = 4
);
  logic          grf_we;
  logic [4:0]    grf_addr;
  logic [31:0]   grf_wdata;
  logic [31:0]   grf_pc;
  logic          dm_we;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_pc;
  logic          rd_ready;
  logic          rd_valid;
  logic          rd_kind;
  logic [31:0]   rd_pc;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_data;
  logic [AW:0]   count;
  logic          overflow;

  // Core + consumer side.
  modport master (
    output grf_we, grf_addr, grf_wdata, grf_pc,
    output dm_we, dm_addr, dm_wdata, dm_pc,
    output rd_ready,
    input  rd_valid, rd_kind, rd_pc, rd_addr, rd_data, count, overflow
  );

  // Trace buffer side.
  modport slave (
    input  grf_we, grf_addr, grf_wdata, grf_pc,
    input  dm_we, dm_addr, dm_wdata, dm_pc,
    input  rd_ready,
    output rd_valid, rd_kind, rd_pc, rd_addr, rd_data, count, overflow
  );
endinterface

// File: rtl/commit_trace_buffer_mem.sv
// Record storage: DEPTH x TRACE_W register array with two write ports
// (port 0 at wr_ptr, port 1 at wr_ptr+1) and one asynchronous read port.
// Contents are not reset; validity is tracked by the top-level count.
module trace_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] wr_ptr,
  input  trace_rec_t    wdata0,
  input  trace_rec_t    wdata1,
  input  logic [AW-1:0] rd_ptr,
  output trace_rec_t    rdata
);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr1;

  // Second port targets the next slot; wraps naturally at AW bits.
  always_comb begin
    wr_ptr1 = wr_ptr + AW'(1);
  end

  // Both ports may write in the same cycle; DEPTH >= 2 keeps the slots distinct.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wr_ptr]  <= wdata0;
    if (we1) mem_q[wr_ptr1] <= wdata1;
  end

  // Asynchronous read of the head slot.
  always_comb begin
    rdata = mem_q[rd_ptr];
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Passive commit-stream observer: turns retired GRF writes and DM stores
// into FIFO trace records. Records that do not fit are dropped and the
// sticky overflow flag is raised; the core is never back-pressured.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  commit_trace_buffer_if.slave  bus
);

  localparam int FW = AW + 2;  // wide enough for DEPTH + 1

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          overflow_q, overflow_d;

  logic          grf_cand, dm_cand;
  logic          grf_push, dm_push;
  logic          rd_valid, pop, drop;
  logic [FW-1:0] free;
  logic          we0, we1;
  logic [1:0]    n_push;
  trace_rec_t    grf_rec, dm_rec, wdata0, wdata1, head;

  // Admission: work out what can be pushed given the slots free this cycle.
  always_comb begin
    grf_cand = bus.grf_we && (bus.grf_addr != 5'd0);
    dm_cand  = bus.dm_we;
    rd_valid = (count_q != '0);
    pop      = rd_valid && bus.rd_ready;
    // A same-cycle pop releases its slot for an incoming record.
    free     = FW'(DEPTH) - FW'(count_q) + FW'(pop);

    // GRF is ordered first, so it claims the first free slot.
    grf_push = grf_cand && (free >= FW'(1));
    dm_push  = dm_cand && (grf_push ? (free >= FW'(2)) : (free >= FW'(1)));
    drop     = (grf_cand && !grf_push) || (dm_cand && !dm_push);

    grf_rec  = mk_rec(TRACE_GRF, bus.grf_pc, {27'd0, bus.grf_addr}, bus.grf_wdata);
    dm_rec   = mk_rec(TRACE_DM, bus.dm_pc, bus.dm_addr, bus.dm_wdata);

    // Port 0 always carries the older record of the cycle.
    we0      = grf_push || dm_push;
    we1      = grf_push && dm_push;
    wdata0   = grf_push ? grf_rec : dm_rec;
    wdata1   = dm_rec;
    n_push   = {1'b0, we0} + {1'b0, we1};

    wr_ptr_d   = wr_ptr_q + AW'(n_push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(n_push) - (AW+1)'(pop);
    overflow_d = overflow_q || drop;
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  trace_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .we0    (we0),
    .we1    (we1),
    .wr_ptr (wr_ptr_q),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rd_ptr (rd_ptr_q),
    .rdata  (head)
  );

  // Head fields are forced to zero when the buffer is empty, which also
  // makes them read zero immediately when reset clears count.
  always_comb begin
    bus.rd_valid = rd_valid;
    bus.rd_kind  = rd_valid ? head.kind : 1'b0;
    bus.rd_pc    = rd_valid ? head.pc   : 32'd0;
    bus.rd_addr  = rd_valid ? head.addr : 32'd0;
    bus.rd_data  = rd_valid ? head.data : 32'd0;
    bus.count    = count_q;
    bus.overflow = overflow_q;
  end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Passive observer on the CPU commit side: captures every architectural write the `mips` core retires (GRF writeback and DM store) and queues it as a trace record for an in-design consumer (UART dumper, checker, or bench). It is the read end of the core's commit stream: the core never stalls for it; records that do not fit are dropped and flagged. Sits beside `mips`, tapping the same signals the core drives into GRF and DM.

## Interface
- `DEPTH`, 16, number of record slots; power of two, ≥ 2
- `AW`, 4, log2(DEPTH)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `grf_we`  in  1  GRF write commits this cycle
- `grf_addr`  in  5  destination register
- `grf_wdata`  in  32  value written
- `grf_pc`  in  32  PC of the committing instruction
- `dm_we`  in  1  DM store commits this cycle
- `dm_addr`  in  32  byte address of store
- `dm_wdata`  in  32  stored word
- `dm_pc`  in  32  PC of the storing instruction
- `rd_ready`  in  1  consumer accepts head record
- `rd_valid`  out  1  head record present
- `rd_kind`  out  1  0 = GRF record, 1 = DM record
- `rd_pc`  out  32  record PC
- `rd_addr`  out  32  GRF index zero-extended, or DM address
- `rd_data`  out  32  written value
- `count`  out  AW+1  records held, 0..DEPTH
- `overflow`  out  1  sticky: at least one record dropped

## Operation
- Candidate GRF record when `grf_we && grf_addr != 0`; writes to $0 are ignored entirely (never enqueued, never counted as dropped).
- Candidate DM record when `dm_we`.
- Pop = `rd_valid && rd_ready`. free = DEPTH − count + pop (a same-cycle pop frees its slot).
- Both candidates in one cycle: GRF record ordered before DM record. free ≥ 2 → both pushed; free = 1 → GRF pushed, DM dropped; free = 0 → both dropped.
- Single candidate: pushed if free ≥ 1, else dropped.
- Any drop sets `overflow`; cleared only by `reset`.
- Strict FIFO order; pointers wrap modulo DEPTH; count = pushes − pops, never exceeds DEPTH.
- Head outputs are `rd_*` of the oldest record; they hold stable while `rd_valid && !rd_ready`. When `rd_valid = 0`, `rd_kind/pc/addr/data` read 0.

## Timing
- Reset (async assert, sync release on next edge): `rd_valid=0`, `rd_*=0`, `count=0`, `overflow=0`, pointers 0. Reset mid-stream discards all records.
- Push latency: record committed at edge N is visible on `rd_*` with `rd_valid=1` after edge N (registered storage, no combinational input→output path).
- Pop at edge N: next record (if any) on `rd_*` after edge N; one record per cycle throughput.
- Full + pop + one push same cycle: both occur, count stays DEPTH, no drop.
- Empty + push same cycle as `rd_ready=1`: no pop (nothing valid yet); record appears next cycle.
- `count` and `overflow` updated on the same edge as push/pop.

## Structure
- Package `trace_pkg`: `TRACE_GRF = 1'b0`, `TRACE_DM = 1'b1`, `TRACE_W = 97` (kind+pc+addr+data), record field offsets.
- Sub-module `trace_mem`: DEPTH×TRACE_W register array, two write ports (port 0 at wr_ptr, port 1 at wr_ptr+1), one async read port at rd_ptr. Top holds pointers, count, admit logic, overflow.

## Test plan
- Reset then single GRF write `$8 <= 0x12345678` @ pc 0x3000, `rd_ready=0` → next cycle `rd_valid=1, kind=0, addr=8, data=0x12345678, pc=0x3000, count=1`; holds stable 3 cycles; raise `rd_ready` → `rd_valid=0, count=0`.
- `grf_we` with `grf_addr=0` for 5 cycles → `count=0`, `overflow=0`.
- Same cycle GRF `$2 <= 5` and DM `[0x10] <= 7` → two records, GRF first then DM (`kind=1, addr=0x10, data=7`), `count=2`.
- DEPTH=16, `rd_ready=0`, 17 GRF writes → `count=16`, `overflow=1` after 17th; drain shows first 16 in order with wrap-around intact.
- Full, `rd_ready=1`, one GRF push each cycle for 20 cycles → `count` stays 16, no new overflow, output order matches input order.
- 5 records queued, assert `reset` mid-cycle → outputs 0 immediately (asynchronously); after release a new push appears as sole record, `count=1`.
